// File: rtl/gate_test_sequencer_pkg.sv
// Shared encodings for the gate test sequencer: gate opcodes and FSM states.
package gate_test_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        APPLY = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic [1:0] LAST_VEC = 2'd3;

endpackage

// File: rtl/gate_test_sequencer_ref_model.sv
// Combinational reference: expected gate output for the latched opcode.
module gate_ref_model
    import gate_test_sequencer_pkg::*;
(
    input  op_e  op,
    input  logic a,
    input  logic b,
    output logic z_exp
);

    always_comb begin
        z_exp = 1'b0;
        case (op)
            OP_AND:  z_exp = a & b;
            OP_OR:   z_exp = a | b;
            OP_XOR:  z_exp = a ^ b;
            OP_NAND: z_exp = ~(a & b);
            default: z_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_test_sequencer.sv
// Sweeps a 2-input gate through its truth table and scores z against the
// selected reference function.
//
// state | meaning
// IDLE  | a=b=0, waiting for start
// APPLY | drive {a,b}=index, settle counter runs down
// CHECK | compare z with reference, advance index
// DONE  | one-cycle done pulse, pass valid
module gate_test_sequencer
    import gate_test_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic       a,
    output logic       b,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic       fail_seen,
    output logic [1:0] fail_vec
);

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] idx_q, idx_d;
    op_e        op_q, op_d;
    logic [2:0] err_q, err_d;
    logic       fail_seen_q, fail_seen_d;
    logic [1:0] fail_vec_q, fail_vec_d;
    logic       pass_q, pass_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       z_exp;

    gate_ref_model u_ref (
        .op    (op_q),
        .a     (idx_q[1]),
        .b     (idx_q[0]),
        .z_exp (z_exp)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        op_d        = op_q;
        err_d       = err_q;
        fail_seen_d = fail_seen_q;
        fail_vec_d  = fail_vec_q;
        pass_d      = pass_q;
        a_d         = a_q;
        b_d         = b_q;

        case (state_q)
            IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (start) begin
                    state_d     = APPLY;
                    idx_d       = 2'd0;
                    cnt_d       = SETTLE_LOAD;
                    op_d        = op_e'(op);
                    err_d       = 3'd0;
                    fail_seen_d = 1'b0;
                    fail_vec_d  = 2'd0;
                    pass_d      = 1'b0;
                end
            end
            APPLY: begin
                if (cnt_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CHECK: begin
                if (z != z_exp) begin
                    err_d = err_q + 3'd1;
                    if (!fail_seen_q) begin
                        fail_seen_d = 1'b1;
                        fail_vec_d  = idx_q;
                    end
                end
                if (idx_q == LAST_VEC) begin
                    state_d = DONE;
                    // pass must include this final comparison
                    pass_d  = (err_d == 3'd0);
                end else begin
                    state_d = APPLY;
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = SETTLE_LOAD;
                    a_d     = idx_d[1];
                    b_d     = idx_d[0];
                end
            end
            DONE: begin
                state_d = IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == APPLY) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= 2'd0;
            op_q        <= OP_AND;
            err_q       <= 3'd0;
            fail_seen_q <= 1'b0;
            fail_vec_q  <= 2'd0;
            pass_q      <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            err_q       <= err_d;
            fail_seen_q <= fail_seen_d;
            fail_vec_q  <= fail_vec_d;
            pass_q      <= pass_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_seen = fail_seen_q;
    assign fail_vec  = fail_vec_q;

endmodule
